analog_status_readout: RTL and testbench
========================================

// Module: analog_status_readout
// PURPOSE
//  Return path of the analog student subsystem: the digital status word from the analog block reaches the pmod pins.
//  The block does three things:
//  - synchronises and de-glitches the asynchronous 16-bit status word from the analog block;
//  - queues each new stable value in a small FIFO;
//  - sends each entry to an off-chip host as two bytes over a 4-phase req/ack handshake on the pmod GPIO.
//  Instantiated in student_ss_analog next to the analog black box; it owns the pmod_gpo / pmod_gpio_oe drive.
// PARAMETERS
//  FIFO_DEPTH   4   entries in the status queue; power of 2, >=2
//  STABLE_CYC   4   consecutive identical synced samples needed to accept a value; >=1
//  SYNC_STAGES  2   flops in each synchroniser (status bus, host req, host clr); >=2
// PORTS
//  clk_in        in   1   subsystem clock
//  reset_int     in   1   asynchronous, active-high reset
//  analog_status in   16  asynchronous status word from the analog block
//  pmod_gpi      in   16  [0]=host_req, [1]=host_clr_ovf, [15:2] unused
//  pmod_gpo      out  16  [7:0]=data byte, [8]=ack, [9]=empty, [10]=ovf, [15:11]=0
//  pmod_gpio_oe  out  16  0=pin driven by chip, 1=pin is input; constant 16'hF800
// BEHAVIOUR
//  Reset (async assert; sync release is the integrator's job)
//   - pmod_gpo = 16'h0200: empty=1, all other bits 0
//   - FSM in IDLE; FIFO empty; sync flops, candidate register, stable counter, last_pushed and ovf all cleared
//   - reset mid-handshake aborts the transfer; the unsent word is lost
//  Capture
//   - analog_status passes through SYNC_STAGES flops to give sync_q
//   - sync_q != candidate: load candidate, set cnt = 1
//   - otherwise cnt saturates at STABLE_CYC
//   - push candidate on the cycle cnt first reaches STABLE_CYC, only if candidate != last_pushed
//   - last_pushed resets to 0, so a steady 0 after reset is never pushed
//   - latency from analog_status change to FIFO write: SYNC_STAGES + STABLE_CYC cycles
//   - FIFO full and no pop in the same cycle: the word is dropped and ovf is set (sticky); last_pushed still updates
//   - push and pop in the same cycle while full: both happen, ovf unchanged
//   - rising edge of synced host_clr_ovf clears ovf; if it coincides with a drop, the set wins
//  Transmit FSM (host_req is synced first; every output is registered)
//   - IDLE:   req_s=1 and FIFO not empty -> drive data = head[7:0] -> LO_SET
//   - LO_SET: one cycle of data setup, then ack=1 -> LO_ACK
//   - LO_ACK: req_s=0 -> ack=0 -> HI_WAIT
//   - HI_WAIT: req_s=1 -> drive data = head[15:8] -> HI_SET
//   - HI_SET: then ack=1 -> HI_ACK
//   - HI_ACK: req_s=0 -> ack=0, pop FIFO -> IDLE
//   - data byte holds its value from the SET cycle until the next SET
//   - req=1 while the FIFO is empty: stay in IDLE, ack=0; the host polls the empty bit
//   - empty = registered FIFO-empty flag, one cycle behind a push or pop
// STRUCTURE
//  - analog_readout_pkg:
//    - tx_state_e enum {IDLE, LO_SET, LO_ACK, HI_WAIT, HI_SET, HI_ACK}
//    - pin constants: GPI_REQ=0, GPI_CLR=1, GPO_ACK=8, GPO_EMPTY=9, GPO_OVF=10
//    - OE_MASK = 16'hF800
//  - sub-module analog_readout_fifo: sync FIFO, DEPTH x 16; ptrs one bit wider than the index;
//    full/empty from pointer compare; push_ok = !full | pop
//  - synchronisers are plain flop chains in this module; no separate CDC cell
// TESTING
//  - Reset: assert reset_int mid-LO_ACK -> pmod_gpo == 16'h0200 within 0 cycles (async); FIFO empty after release
//  - Stable capture: analog_status 16'hA55A held 10 cycles -> one push, FIFO count 1, empty falls
//    after 2+4+1 cycles; same value held 100 more cycles -> no second push
//  - Glitch reject: analog_status 16'h1234 held 3 cycles, then back to 0 -> no push, empty stays 1
//  - Full handshake: queued 16'hBEEF; host req up/down twice -> bytes 8'hEF then 8'hBE, each stable
//    while ack=1; empty=1 afterwards
//  - Overflow: push 5 distinct values (16'h0001..16'h0005) with no reads -> 4 queued, ovf=1,
//    readback gives 1..4; pulse gpi[1] -> ovf=0
//  - Req while empty: hold gpi[0]=1 for 50 cycles with empty FIFO -> ack stays 0; then push 16'h00C3
//    -> ack rises within SYNC_STAGES+STABLE_CYC+3 cycles with data 8'hC3

Source files
------------

// File: rtl/analog_readout_pkg.sv
// Shared types and pin map for the analog status readout path.
//   tx_state_e : host transmit handshake states
//   GPI_* / GPO_* : bit positions on the pmod GPIO bus
//   OE_MASK    : constant output-enable pattern (1 = pin is an input)
package analog_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LO_SET,
    LO_ACK,
    HI_WAIT,
    HI_SET,
    HI_ACK
  } tx_state_e;

  localparam int GPI_REQ   = 0;
  localparam int GPI_CLR   = 1;
  localparam int GPO_ACK   = 8;
  localparam int GPO_EMPTY = 9;
  localparam int GPO_OVF   = 10;

  localparam logic [15:0] OE_MASK = 16'hF800;

endpackage

// File: rtl/analog_readout_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, for the captured status words.
// Ports:
//   clk_in, reset_int : clock, async active-high reset
//   push, wdata       : write request and data (ignored when full unless popping)
//   pop               : read request (ignored when empty)
//   rdata             : head entry, valid whenever !empty
//   full, empty       : combinational flags from the pointer compare
module analog_readout_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset_int,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A pop frees the head slot on the same edge, so a push into a full FIFO is fine then.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/analog_status_readout.sv
// Return path from the analog block to the pmod pins: synchronise and
// de-glitch the 16-bit status word, queue each new stable value, and ship
// each entry to the host as two bytes over a 4-phase req/ack handshake.
// Ports:
//   clk_in        : subsystem clock
//   reset_int     : async active-high reset
//   analog_status : asynchronous status word from the analog block
//   pmod_gpi      : [0] host req, [1] host clear-overflow, rest unused
//   pmod_gpo      : [7:0] data byte, [8] ack, [9] empty, [10] ovf, [15:11] 0
//   pmod_gpio_oe  : constant output-enable mask
//
// state   | meaning
// IDLE    | waiting for host req with a non-empty queue
// LO_SET  | low byte on the pins, one cycle of setup before ack
// LO_ACK  | ack high for low byte, waiting for req to drop
// HI_WAIT | low byte done, waiting for req for the high byte
// HI_SET  | high byte on the pins, setup cycle
// HI_ACK  | ack high for high byte, waiting for req to drop, then pop
module analog_status_readout
  import analog_readout_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int STABLE_CYC  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic [15:0] analog_status,
  input  logic [15:0] pmod_gpi,
  output logic [15:0] pmod_gpo,
  output logic [15:0] pmod_gpio_oe
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYC);

  logic [15:0]            status_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   clr_d;
  logic [15:0]            sync_q;
  logic                   req_s;
  logic                   clr_s;

  logic [15:0]   candidate;
  logic [15:0]   cand_nxt;
  logic [15:0]   last_pushed;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          changed;
  logic          stable_evt;
  logic          push;
  logic          pop;
  logic          drop;

  logic [15:0] head;
  logic        fifo_full;
  logic        fifo_empty;

  tx_state_e   state;
  logic [7:0]  data_r;
  logic        ack_r;
  logic        empty_r;
  logic        ovf_r;

  logic        unused_gpi;
  assign unused_gpi = ^pmod_gpi[15:2];

  assign sync_q = status_sync[SYNC_STAGES-1];
  assign req_s  = req_sync[SYNC_STAGES-1];
  assign clr_s  = clr_sync[SYNC_STAGES-1];

  always_comb begin
    changed  = (sync_q != candidate);
    cand_nxt = changed ? sync_q : candidate;
    if (changed)                 cnt_nxt = CW'(1);
    else if (cnt == STABLE_MAX)  cnt_nxt = cnt;
    else                         cnt_nxt = cnt + 1'b1;
    // Fires once per stable run, including a reload when STABLE_CYC is 1.
    stable_evt = (cnt_nxt == STABLE_MAX) && (changed || (cnt != STABLE_MAX));
    push       = stable_evt && (cand_nxt != last_pushed);
  end

  assign pop  = (state == HI_ACK) && !req_s;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      for (int i = 0; i < SYNC_STAGES; i++) status_sync[i] <= '0;
      req_sync    <= '0;
      clr_sync    <= '0;
      clr_d       <= 1'b0;
      candidate   <= '0;
      cnt         <= '0;
      last_pushed <= '0;
      ovf_r       <= 1'b0;
      empty_r     <= 1'b1;
    end else begin
      status_sync[0] <= analog_status;
      for (int i = 1; i < SYNC_STAGES; i++) status_sync[i] <= status_sync[i-1];
      req_sync  <= {req_sync[SYNC_STAGES-2:0], pmod_gpi[GPI_REQ]};
      clr_sync  <= {clr_sync[SYNC_STAGES-2:0], pmod_gpi[GPI_CLR]};
      clr_d     <= clr_s;
      candidate <= cand_nxt;
      cnt       <= cnt_nxt;
      // last_pushed tracks accepted values even when the FIFO drops them.
      if (push) last_pushed <= cand_nxt;
      if (drop)                 ovf_r <= 1'b1;
      else if (clr_s && !clr_d) ovf_r <= 1'b0;
      empty_r <= fifo_empty;
    end
  end

  analog_readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_in    (clk_in),
    .reset_int (reset_int),
    .push      (push),
    .wdata     (cand_nxt),
    .pop       (pop),
    .rdata     (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      state  <= IDLE;
      data_r <= '0;
      ack_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s && !fifo_empty) begin
            data_r <= head[7:0];
            state  <= LO_SET;
          end
        end
        LO_SET: begin
          ack_r <= 1'b1;
          state <= LO_ACK;
        end
        LO_ACK: begin
          if (!req_s) begin
            ack_r <= 1'b0;
            state <= HI_WAIT;
          end
        end
        HI_WAIT: begin
          if (req_s) begin
            data_r <= head[15:8];
            state  <= HI_SET;
          end
        end
        HI_SET: begin
          ack_r <= 1'b1;
          state <= HI_ACK;
        end
        HI_ACK: begin
          if (!req_s) begin
            ack_r <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pmod_gpo     = {5'b0, ovf_r, empty_r, ack_r, data_r};
  assign pmod_gpio_oe = OE_MASK;

endmodule

// File: tb/tb_analog_status_readout.sv
// Self-checking bench for analog_status_readout.
module tb_analog_status_readout;
  import analog_readout_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_int;
  logic [15:0] analog_status;
  logic [15:0] pmod_gpi;
  logic [15:0] pmod_gpo;
  logic [15:0] pmod_gpio_oe;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  analog_status_readout #(
    .FIFO_DEPTH  (4),
    .STABLE_CYC  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in        (clk_in),
    .reset_int     (reset_int),
    .analog_status (analog_status),
    .pmod_gpi      (pmod_gpi),
    .pmod_gpo      (pmod_gpo),
    .pmod_gpio_oe  (pmod_gpio_oe)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_ack(input logic v, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (pmod_gpo[GPO_ACK] === v) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  // One full two-byte host transfer. first_w holds the bytes seen as ack rose,
  // last_w the bytes seen just before req dropped.
  task automatic host_read(output logic [15:0] first_w, output logic [15:0] last_w, output bit tmo);
    bit t;
    tmo = 1'b0;
    pmod_gpi[GPI_REQ] = 1'b1;
    wait_ack(1'b1, t); tmo |= t;
    first_w[7:0] = pmod_gpo[7:0];
    cycles(3);
    last_w[7:0] = pmod_gpo[7:0];
    pmod_gpi[GPI_REQ] = 1'b0;
    wait_ack(1'b0, t); tmo |= t;
    pmod_gpi[GPI_REQ] = 1'b1;
    wait_ack(1'b1, t); tmo |= t;
    first_w[15:8] = pmod_gpo[7:0];
    cycles(3);
    last_w[15:8] = pmod_gpo[7:0];
    pmod_gpi[GPI_REQ] = 1'b0;
    wait_ack(1'b0, t); tmo |= t;
  endtask

  task automatic test_reset;
    reset_int = 1'b1;
    cycles(3);
    checks++;
    if (pmod_gpo !== 16'h0200) begin
      errors++;
      $display("FAIL reset_gpo: got %h expected 0200", pmod_gpo);
    end
    checks++;
    if (pmod_gpio_oe !== 16'hF800) begin
      errors++;
      $display("FAIL reset_oe: got %h expected f800", pmod_gpio_oe);
    end
    reset_int = 1'b0;
    exp_q.delete();
    cycles(10);
    checks++;
    if (pmod_gpo !== 16'h0200) begin
      errors++;
      $display("FAIL post_reset_gpo: got %h expected 0200", pmod_gpo);
    end
  endtask

  task automatic test_glitch;
    analog_status = 16'h1234;
    cycles(3);
    analog_status = 16'h0000;
    cycles(20);
    checks++;
    if (pmod_gpo[GPO_EMPTY] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_empty: got %b expected 1", pmod_gpo[GPO_EMPTY]);
    end
  endtask

  task automatic test_capture;
    logic [15:0] w0, w1, exp_w;
    bit tmo;
    analog_status = 16'hA55A;
    exp_q.push_back(16'hA55A);
    cycles(6);
    checks++;
    if (pmod_gpo[GPO_EMPTY] !== 1'b1) begin
      errors++;
      $display("FAIL capture_empty_early: got %b expected 1", pmod_gpo[GPO_EMPTY]);
    end
    cycles(1);
    checks++;
    if (pmod_gpo[GPO_EMPTY] !== 1'b0) begin
      errors++;
      $display("FAIL capture_empty_fall: got %b expected 0", pmod_gpo[GPO_EMPTY]);
    end
    cycles(100);
    host_read(w0, w1, tmo);
    exp_w = exp_q.pop_front();
    checks++;
    if (tmo || w0 !== exp_w) begin
      errors++;
      $display("FAIL capture_read: got %h tmo=%0d expected %h", w0, tmo, exp_w);
    end
    cycles(3);
    checks++;
    if (pmod_gpo[GPO_EMPTY] !== 1'b1) begin
      errors++;
      $display("FAIL capture_single_push: empty got %b expected 1", pmod_gpo[GPO_EMPTY]);
    end
  endtask

  task automatic test_handshake;
    logic [15:0] w0, w1, exp_w;
    bit tmo;
    analog_status = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    cycles(10);
    host_read(w0, w1, tmo);
    exp_w = exp_q.pop_front();
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL hs_timeout: got tmo=1 expected 0");
    end
    checks++;
    if (w0[7:0] !== exp_w[7:0] || w1[7:0] !== exp_w[7:0]) begin
      errors++;
      $display("FAIL hs_lo_byte: got %h/%h expected %h", w0[7:0], w1[7:0], exp_w[7:0]);
    end
    checks++;
    if (w0[15:8] !== exp_w[15:8] || w1[15:8] !== exp_w[15:8]) begin
      errors++;
      $display("FAIL hs_hi_byte: got %h/%h expected %h", w0[15:8], w1[15:8], exp_w[15:8]);
    end
    cycles(3);
    checks++;
    if (pmod_gpo[GPO_EMPTY] !== 1'b1) begin
      errors++;
      $display("FAIL hs_empty_after: got %b expected 1", pmod_gpo[GPO_EMPTY]);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] w0, w1, exp_w;
    bit tmo;
    for (int v = 1; v <= 5; v++) begin
      analog_status = 16'(v);
      if (v <= 4) exp_q.push_back(16'(v));
      cycles(10);
    end
    checks++;
    if (pmod_gpo[GPO_OVF] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", pmod_gpo[GPO_OVF]);
    end
    for (int k = 0; k < 4; k++) begin
      host_read(w0, w1, tmo);
      exp_w = exp_q.pop_front();
      checks++;
      if (tmo || w0 !== exp_w || w1 !== exp_w) begin
        errors++;
        $display("FAIL ovf_readback[%0d]: got %h/%h tmo=%0d expected %h", k, w0, w1, tmo, exp_w);
      end
    end
    cycles(3);
    checks++;
    if (pmod_gpo[GPO_EMPTY] !== 1'b1 || pmod_gpo[GPO_OVF] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: got empty=%b ovf=%b expected empty=1 ovf=1",
               pmod_gpo[GPO_EMPTY], pmod_gpo[GPO_OVF]);
    end
    pmod_gpi[GPI_CLR] = 1'b1;
    cycles(3);
    pmod_gpi[GPI_CLR] = 1'b0;
    cycles(5);
    checks++;
    if (pmod_gpo[GPO_OVF] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", pmod_gpo[GPO_OVF]);
    end
  endtask

  task automatic test_req_while_empty;
    int  bad_ack = 0;
    bit  seen = 1'b0;
    bit  tmo;
    logic [15:0] exp_w;
    logic [7:0]  hi;
    pmod_gpi[GPI_REQ] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (pmod_gpo[GPO_ACK] !== 1'b0) bad_ack++;
    end
    checks++;
    if (bad_ack != 0) begin
      errors++;
      $display("FAIL req_empty_ack: got %0d cycles with ack=1 expected 0", bad_ack);
    end
    analog_status = 16'h00C3;
    exp_q.push_back(16'h00C3);
    for (int i = 0; i < 2 + 4 + 3; i++) begin
      @(negedge clk_in);
      if (pmod_gpo[GPO_ACK] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    exp_w = exp_q.pop_front();
    checks++;
    if (!seen || pmod_gpo[7:0] !== exp_w[7:0]) begin
      errors++;
      $display("FAIL req_empty_latency: got ack_seen=%0d data=%h expected 1 %h",
               seen, pmod_gpo[7:0], exp_w[7:0]);
    end
    pmod_gpi[GPI_REQ] = 1'b0;
    wait_ack(1'b0, tmo);
    pmod_gpi[GPI_REQ] = 1'b1;
    wait_ack(1'b1, tmo);
    hi = pmod_gpo[7:0];
    pmod_gpi[GPI_REQ] = 1'b0;
    wait_ack(1'b0, tmo);
    checks++;
    if (tmo || hi !== exp_w[15:8]) begin
      errors++;
      $display("FAIL req_empty_hi: got %h tmo=%0d expected %h", hi, tmo, exp_w[15:8]);
    end
  endtask

  task automatic test_reset_mid;
    bit tmo;
    analog_status = 16'h7777;
    exp_q.push_back(16'h7777);
    cycles(10);
    pmod_gpi[GPI_REQ] = 1'b1;
    wait_ack(1'b1, tmo);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL mid_reset_setup: got ack timeout expected ack=1");
    end
    #2;
    reset_int     = 1'b1;
    analog_status = 16'h0000;
    pmod_gpi      = 16'h0000;
    #1;
    checks++;
    if (pmod_gpo !== 16'h0200) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected 0200", pmod_gpo);
    end
    cycles(2);
    reset_int = 1'b0;
    exp_q.delete();
    cycles(20);
    checks++;
    if (pmod_gpo !== 16'h0200) begin
      errors++;
      $display("FAIL mid_reset_release: got %h expected 0200", pmod_gpo);
    end
  endtask

  initial begin
    reset_int     = 1'b1;
    analog_status = 16'h0000;
    pmod_gpi      = 16'h0000;
    test_reset();
    test_glitch();
    test_capture();
    test_handshake();
    test_overflow();
    test_req_while_empty();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
